// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: block layout, sync headers, block types,
// scrambler taps and the receive lock state encoding.
package pcs_pkg;

    localparam int unsigned SH_W      = 2;
    localparam int unsigned PAYLOAD_W = 64;
    localparam int unsigned BLOCK_W   = SH_W + PAYLOAD_W;

    localparam logic [SH_W-1:0] SYNC_DATA = 2'b10;
    localparam logic [SH_W-1:0] SYNC_CTL  = 2'b01;

    // Scrambler polynomial 1 + x^39 + x^58
    localparam int unsigned SCR_TAP_A = 39;
    localparam int unsigned SCR_TAP_B = 58;

    typedef enum logic [7:0] {
        BT_IDLE   = 8'h1e,
        BT_OS_D4  = 8'h2d,
        BT_S4     = 8'h33,
        BT_OS_S4  = 8'h66,
        BT_S4_OS  = 8'h55,
        BT_S0     = 8'h78,
        BT_OS_D0  = 8'h4b,
        BT_T0     = 8'h87,
        BT_T1     = 8'h99,
        BT_T2     = 8'haa,
        BT_T3     = 8'hb4,
        BT_T4     = 8'hcc,
        BT_T5     = 8'hd2,
        BT_T6     = 8'he1,
        BT_T7     = 8'hff
    } block_type_t;

    typedef struct packed {
        logic [SH_W-1:0]      sh;
        logic [PAYLOAD_W-1:0] payload;
    } block_t;

    typedef enum logic [1:0] {
        ST_LOCK_INIT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } lock_state_t;

    function automatic logic sh_is_valid(input logic [SH_W-1:0] sh);
        return (sh == SYNC_DATA) || (sh == SYNC_CTL);
    endfunction

endpackage

// File: rtl/descrambler_64.sv
// 64-bit parallel self-synchronous descrambler for 1 + x^39 + x^58.
// State keeps the most recent 58 scrambled bits; output is combinational.
module descrambler_64
    import pcs_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [PAYLOAD_W-1:0] din,
    output logic [PAYLOAD_W-1:0] dout_c
);

    localparam int unsigned ST_W   = SCR_TAP_B;
    localparam int unsigned HIST_W = PAYLOAD_W + SCR_TAP_B - SCR_TAP_A;
    localparam int unsigned NEW_W  = HIST_W - ST_W;

    logic [ST_W-1:0]   state;
    logic [HIST_W-1:0] hist;

    // hist[k] is stream bit (n - 58 + k) relative to payload bit 0 at n
    assign hist = {din[NEW_W-1:0], state};

    always_comb begin
        dout_c = '0;
        for (int i = 0; i < int'(PAYLOAD_W); i++) begin
            dout_c[i] = din[i]
                      ^ hist[i + int'(ST_W) - int'(SCR_TAP_A)]
                      ^ hist[i + int'(ST_W) - int'(SCR_TAP_B)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
        end else if (en) begin
            state <= din[PAYLOAD_W-1 -: ST_W];
        end
    end

endmodule

// File: rtl/rx_block_lock.sv
// 64b/66b receive block synchroniser: hunts sync-header alignment via gearbox
// slips, tracks block lock, and forwards descrambled blocks while locked.
module rx_block_lock
    import pcs_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX     = 64,
    parameter int unsigned SH_INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT      = 2
) (
    input  logic               i_rxc,
    input  logic               i_reset,
    input  logic [BLOCK_W-1:0] i_rxd,
    input  logic               i_rx_valid,
    output logic               o_slip,
    output logic               o_block_lock,
    output logic [BLOCK_W-1:0] o_rxd,
    output logic               o_rx_valid
);

    localparam int unsigned CNT_W  = 7;
    localparam int unsigned INV_W  = 5;
    localparam int unsigned WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    lock_state_t          state;
    logic [CNT_W-1:0]     sh_cnt;
    logic [INV_W-1:0]     sh_invalid_cnt;
    logic [WAIT_W-1:0]    wait_cnt;

    block_t               blk;
    logic [PAYLOAD_W-1:0] descr_c;
    logic                 hdr_ok_c;
    logic [CNT_W-1:0]     cnt_inc_c;
    logic [INV_W-1:0]     inv_inc_c;
    logic                 test_blk_c;
    logic                 slip_c;
    logic                 window_end_c;
    logic                 lock_next_c;

    assign blk = block_t'(i_rxd);

    descrambler_64 u_descrambler (
        .clk    (i_rxc),
        .reset  (i_reset),
        .en     (i_rx_valid),
        .din    (blk.payload),
        .dout_c (descr_c)
    );

    // Per-block header test decode; the slip outranks a coincident window end
    always_comb begin
        hdr_ok_c     = sh_is_valid(blk.sh);
        cnt_inc_c    = sh_cnt + CNT_W'(1);
        inv_inc_c    = sh_invalid_cnt + INV_W'(!hdr_ok_c);
        test_blk_c   = (state == ST_TEST_SH) && i_rx_valid;
        slip_c       = test_blk_c && !hdr_ok_c &&
                       (!o_block_lock || (inv_inc_c == INV_W'(SH_INVALID_MAX)));
        window_end_c = test_blk_c && !slip_c && (cnt_inc_c == CNT_W'(SH_CNT_MAX));
        lock_next_c  = o_block_lock;
        if (state == ST_LOCK_INIT || slip_c) begin
            lock_next_c = 1'b0;
        end else if (window_end_c && (inv_inc_c == '0)) begin
            lock_next_c = 1'b1;
        end
    end

    always_ff @(posedge i_rxc) begin
        if (i_reset) begin
            state          <= ST_LOCK_INIT;
            sh_cnt         <= '0;
            sh_invalid_cnt <= '0;
            wait_cnt       <= '0;
            o_slip         <= 1'b0;
            o_block_lock   <= 1'b0;
            o_rxd          <= '0;
            o_rx_valid     <= 1'b0;
        end else begin
            o_slip       <= slip_c;
            o_block_lock <= lock_next_c;
            o_rx_valid   <= i_rx_valid && lock_next_c;
            if (i_rx_valid && lock_next_c) begin
                o_rxd <= {blk.sh, descr_c};
            end

            case (state)
                ST_LOCK_INIT: begin
                    sh_cnt         <= '0;
                    sh_invalid_cnt <= '0;
                    wait_cnt       <= '0;
                    state          <= ST_TEST_SH;
                end
                ST_TEST_SH: begin
                    if (i_rx_valid) begin
                        if (slip_c) begin
                            sh_cnt         <= '0;
                            sh_invalid_cnt <= '0;
                            wait_cnt       <= '0;
                            state          <= ST_SLIP_WAIT;
                        end else if (window_end_c) begin
                            sh_cnt         <= '0;
                            sh_invalid_cnt <= '0;
                        end else begin
                            sh_cnt         <= cnt_inc_c;
                            sh_invalid_cnt <= inv_inc_c;
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    // Blocks here are discarded while the gearbox realigns
                    if (i_rx_valid) begin
                        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                            wait_cnt       <= '0;
                            sh_cnt         <= '0;
                            sh_invalid_cnt <= '0;
                            state          <= ST_TEST_SH;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_LOCK_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock: directed sequence with random payloads,
// checked every cycle against a bit-serial lock/descrambler reference model.
module tb_rx_block_lock;
    import pcs_pkg::*;

    localparam int unsigned CNT_MAX = 64;
    localparam int unsigned INV_MAX = 16;
    localparam int unsigned WAIT_N  = 2;
    localparam logic [63:0] IDLE_PAYLOAD = {56'h0, 8'h1e};

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [65:0] rxd;
    logic        slip;
    logic        lock;
    logic [65:0] orxd;
    logic        ovalid;

    always #5 clk = ~clk;

    rx_block_lock #(
        .SH_CNT_MAX     (CNT_MAX),
        .SH_INVALID_MAX (INV_MAX),
        .SLIP_WAIT      (WAIT_N)
    ) dut (
        .i_rxc        (clk),
        .i_reset      (rst),
        .i_rxd        (rxd),
        .i_rx_valid   (valid),
        .o_slip       (slip),
        .o_block_lock (lock),
        .o_rxd        (orxd),
        .o_rx_valid   (ovalid)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: phase 0 = just reset, 1 = testing headers, 2 = settling after slip
    int          m_phase;
    int          m_blocks;
    int          m_bad;
    int          m_settle;
    bit          m_lock;
    bit          m_slip;
    bit          m_valid;
    logic [65:0] m_rxd;
    bit          dq[$];
    bit          sq[$];

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_blocks = 0;
        m_bad    = 0;
        m_settle = 0;
        m_lock   = 1'b0;
        m_slip   = 1'b0;
        m_valid  = 1'b0;
        m_rxd    = '0;
        dq.delete();
        repeat (58) dq.push_back(1'b0);
    endtask

    // Bit-serial: d[n] = h[n] ^ h[n-39] ^ h[n-58]; dq[0] is h[n-58], dq[19] is h[n-39]
    task automatic model_descramble(input logic [63:0] r, output logic [63:0] d);
        bit b;
        d = '0;
        for (int i = 0; i < 64; i++) begin
            d[i] = r[i] ^ dq[19] ^ dq[0];
            dq.push_back(r[i]);
            b = dq.pop_front();
        end
    endtask

    task automatic scramble(input logic [63:0] d, output logic [63:0] s);
        bit b;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            s[i] = d[i] ^ sq[19] ^ sq[0];
            sq.push_back(s[i]);
            b = sq.pop_front();
        end
    endtask

    task automatic model_step(input bit v, input logic [65:0] blk);
        logic        bad;
        logic [63:0] d;
        bad     = (blk[65:64] == 2'b00) || (blk[65:64] == 2'b11);
        m_slip  = 1'b0;
        m_valid = 1'b0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (v && m_phase == 1) begin
            m_blocks++;
            if (bad) m_bad++;
            if (bad && (!m_lock || m_bad == int'(INV_MAX))) begin
                m_lock   = 1'b0;
                m_slip   = 1'b1;
                m_phase  = 2;
                m_settle = 0;
                m_blocks = 0;
                m_bad    = 0;
            end else if (m_blocks == int'(CNT_MAX)) begin
                if (m_bad == 0) m_lock = 1'b1;
                m_blocks = 0;
                m_bad    = 0;
            end
        end else if (v && m_phase == 2) begin
            m_settle++;
            if (m_settle == int'(WAIT_N)) begin
                m_phase  = 1;
                m_blocks = 0;
                m_bad    = 0;
            end
        end
        if (v) begin
            model_descramble(blk[63:0], d);
            if (m_lock) begin
                m_valid = 1'b1;
                m_rxd   = {blk[65:64], d};
            end
        end
    endtask

    // One clock: drive at negedge, DUT samples at posedge, compare at next negedge
    task automatic cyc(input bit r, input bit v, input logic [65:0] blk);
        rst   = r;
        valid = v;
        rxd   = blk;
        @(negedge clk);
        if (r) model_reset();
        else   model_step(v, blk);
        check("slip",       66'(slip),   66'(m_slip));
        check("block_lock", 66'(lock),   66'(m_lock));
        check("rx_valid",   66'(ovalid), 66'(m_valid));
        check("rxd",        orxd,        m_rxd);
    endtask

    function automatic logic [65:0] good_blk();
        logic [1:0] sh;
        sh = ($urandom_range(0, 1) == 0) ? SYNC_CTL : SYNC_DATA;
        return {sh, $urandom(), $urandom()};
    endfunction

    function automatic logic [65:0] bad_blk();
        logic [1:0] sh;
        sh = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        return {sh, $urandom(), $urandom()};
    endfunction

    task automatic idle_blk(output logic [65:0] b);
        logic [63:0] s;
        scramble(IDLE_PAYLOAD, s);
        b = {SYNC_CTL, s};
    endtask

    initial begin
        logic [65:0] b;
        int          skip;
        rst   = 1'b1;
        valid = 1'b0;
        rxd   = '0;
        sq.delete();
        repeat (58) sq.push_back(1'b0);
        model_reset();

        // Reset state, including with a block presented during reset
        cyc(1, 0, '0);
        cyc(1, 1, good_blk());
        cyc(0, 0, '0);

        // Scrambled idles with gaps; lock on the 64th valid block, plaintext out
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            idle_blk(b);
            cyc(0, 1, b);
            if (i == int'(CNT_MAX) - 2) check("lock_before_64", 66'(lock), 66'(0));
            if (i == int'(CNT_MAX) - 1) begin
                check("lock_at_64", 66'(lock), 66'(1));
                check("idle_plain_first", orxd, {SYNC_CTL, IDLE_PAYLOAD});
            end
            cyc(0, 0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            idle_blk(b);
            cyc(0, 1, b);
            check("idle_plain", orxd, {SYNC_CTL, IDLE_PAYLOAD});
            check("idle_valid", 66'(ovalid), 66'(1));
        end

        // Complete the current window with random good blocks
        for (int i = 0; i < int'(CNT_MAX) - 4; i++) cyc(0, 1, good_blk());
        check("lock_after_window", 66'(lock), 66'(1));

        // 15 invalid headers in one window keep lock
        skip = $urandom_range(0, 15);
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            if ((i % 4) == 3 && (i / 4) != skip) cyc(0, 1, bad_blk());
            else                                  cyc(0, 1, good_blk());
        end
        check("lock_hold_15", 66'(lock), 66'(1));

        // 16 invalid headers: 16th lands on the window's last block, slip wins
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            if ((i % 4) == 3) cyc(0, 1, bad_blk());
            else              cyc(0, 1, good_blk());
            if (i == int'(CNT_MAX) - 5) check("lock_hold_15th", 66'(lock), 66'(1));
            if (i == int'(CNT_MAX) - 1) begin
                check("lock_fall", 66'(lock), 66'(0));
                check("slip_on_fall", 66'(slip), 66'(1));
            end
        end
        cyc(0, 0, '0);
        check("slip_one_cycle", 66'(slip), 66'(0));

        // Settle, then an unlocked bad header slips once
        for (int i = 0; i < int'(WAIT_N); i++) cyc(0, 1, good_blk());
        cyc(0, 1, {2'b00, $urandom(), $urandom()});
        check("slip_unlocked", 66'(slip), 66'(1));
        cyc(0, 0, '0);
        check("slip_drop", 66'(slip), 66'(0));

        // Two discarded blocks, then 64 good blocks with random gaps to relock
        for (int i = 0; i < int'(WAIT_N); i++) cyc(0, 1, good_blk());
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            if ($urandom_range(0, 1) == 1) cyc(0, 0, good_blk());
            cyc(0, 1, good_blk());
            if (i == int'(CNT_MAX) - 2) check("relock_early", 66'(lock), 66'(0));
            if (i == int'(CNT_MAX) - 1) check("relock", 66'(lock), 66'(1));
        end
        for (int i = 0; i < 8; i++) cyc(0, 1, good_blk());

        // Reset mid-window drops lock immediately; relock needs a full window
        cyc(1, 1, good_blk());
        check("reset_lock", 66'(lock), 66'(0));
        check("reset_valid", 66'(ovalid), 66'(0));
        cyc(0, 0, '0);
        for (int i = 0; i < int'(CNT_MAX); i++) begin
            cyc(0, 1, good_blk());
            if (i == int'(CNT_MAX) - 2) check("post_reset_early", 66'(lock), 66'(0));
            if (i == int'(CNT_MAX) - 1) check("post_reset_lock", 66'(lock), 66'(1));
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, good_blk());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Receive-side 64b/66b block synchroniser and descrambler. It sits between the receive gearbox and the 64/66b decoder. It hunts for sync-header alignment by issuing slip requests to the gearbox, and declares block lock per the IEEE 802.3 Clause 49 lock rules. It self-synchronously descrambles each 64-bit payload and forwards only locked blocks to the decoder's `i_rxd`/`i_rx_valid` input.

## Interface
Parameters:
- `SH_CNT_MAX`, 64: valid blocks per header-test window.
- `SH_INVALID_MAX`, 16: invalid headers in one window that force loss of lock.
- `SLIP_WAIT`, 2: valid blocks discarded after each slip while the gearbox settles (≥1).

Ports:
- `i_rxc`  in  1  receive clock; the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rxd`  in  66  block from gearbox; `[65:64]` sync header, `[63:0]` scrambled payload, payload bit 0 received first.
- `i_rx_valid`  in  1  `i_rxd` holds a new block this cycle.
- `o_slip`  out  1  one-cycle request to gearbox to shift alignment by one bit.
- `o_block_lock`  out  1  block lock achieved.
- `o_rxd`  out  66  header passed through, plus descrambled payload.
- `o_rx_valid`  out  1  `o_rxd` valid; only asserted while locked.

## Operation
- A header is valid when it is `2'b01` (control) or `2'b10` (data). `2'b00` and `2'b11` are invalid.
- Cycles with `i_rx_valid=0` change no state, counter or descrambler bit.
- Counters: `sh_cnt` (7 bits) and `sh_invalid_cnt` (5 bits).
- FSM states: `LOCK_INIT`, `TEST_SH`, `SLIP_WAIT`.
- `LOCK_INIT`: entered on reset. Clears counters and `o_block_lock`, then moves to `TEST_SH` on the next cycle.
- `TEST_SH`, on each valid block:
  - `sh_cnt` increments; `sh_invalid_cnt` also increments if the header is invalid.
  - Invalid header while unlocked: pulse `o_slip`, clear counters, go to `SLIP_WAIT`.
  - Invalid header while locked, with `sh_invalid_cnt` reaching `SH_INVALID_MAX`: `o_block_lock`←0, pulse `o_slip`, clear counters, go to `SLIP_WAIT`.
  - `sh_cnt` reaching `SH_CNT_MAX` without a slip: if `sh_invalid_cnt==0`, set `o_block_lock`←1; clear both counters in either case.
  - A slip condition and window end on the same block: the slip wins.
- `SLIP_WAIT`: counts `SLIP_WAIT` valid blocks and discards them, then returns to `TEST_SH` with counters at 0. Lock is never set here.
- Descrambler: polynomial 1+x^39+x^58, self-synchronous. `d[i] = r[i] ^ h[i-39] ^ h[i-58]`, where `h` is the received scrambled bit stream.
  - Its state holds the last 58 received payload bits and updates to `r[63:6]` on every valid block, locked or not.
  - Its state is cleared to 0 on reset only.
  - Sync headers are never scrambled.

## Timing
- Reset values: `o_slip=0`, `o_block_lock=0`, `o_rxd=0`, `o_rx_valid=0`, descrambler state 0, FSM in `LOCK_INIT`.
- Reset takes priority at any time, mid-window or mid-slip-wait. All outputs read their reset values on the cycle after `i_reset` is sampled high.
- Data latency is 1 cycle. On the cycle after `i_rx_valid` is sampled with a block:
  - `o_rxd` carries that block descrambled.
  - `o_rx_valid` = `i_rx_valid` AND (`o_block_lock` as updated by that same block).
- `o_rxd` holds its value when `o_rx_valid=0`.
- `o_slip` is registered. It is high for exactly 1 cycle, the cycle after the block that caused it.
- `o_block_lock` rises on the cycle after the `SH_CNT_MAX`-th clean block. It falls on the cycle after the `SH_INVALID_MAX`-th invalid header in a window.
- There is no backpressure; every valid input block is consumed.

## Structure
- Shared package `pcs_pkg` holds the sync-header constants (`SYNC_DATA=2'b10`, `SYNC_CTL=2'b01`), the block-type enum, and the scrambler tap constants 39/58. The encoder, decoder and scrambler use this package too.
- Sub-module `descrambler_64`: a 64-bit parallel descrambler with a 58-bit state register, an enable and a synchronous reset. It can be verified standalone.
- The lock FSM and counters stay in `rx_block_lock`.

## Test plan
- Reset, then 64 consecutive blocks with header `2'b01` and gaps of `i_rx_valid=0` between them → `o_block_lock`=1 on the cycle after the 64th valid block, and `o_slip` never asserts.
- Unlocked, one block with header `2'b00` → `o_slip` high for 1 cycle. The next 2 valid blocks cause no count change, and a further 64 good blocks then achieve lock.
- Locked, 15 invalid headers spread over a 64-block window → stays locked. 16 invalid headers in a window → `o_block_lock` falls and `o_slip` pulses once, in the same cycle.
- Locked, payload from a reference scrambler model started at zero state, 4 idle blocks `{2'b01, 56'h0, 8'h1e}` → `o_rxd` equals the unscrambled blocks exactly, and `o_rx_valid`=1 for each.
- Locked, `i_reset` asserted mid-window → next cycle `o_block_lock`=0 and `o_rx_valid`=0. Relock takes a full 64 clean blocks.
- Unlocked, good blocks streamed → `o_rx_valid` stays 0 throughout, and the descrambler state still advances, which is checked against the model after lock.
